// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential signed divider
package div_pkg;

  localparam int DEFAULT_W = 16;
  localparam int CNT_W     = $clog2(DEFAULT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_i,
  input  logic         shift_in_i,
  input  logic [W:0]   b_i,
  output logic [W-1:0] rem_o,
  output logic         qbit_o
);

  logic [W:0] shifted;

  assign shifted = {rem_i, shift_in_i};
  // A non-negative trial difference means the divisor fits: keep the difference, emit a 1.
  assign qbit_o  = (shifted >= b_i);
  assign rem_o   = qbit_o ? W'(shifted - b_i) : shifted[W-1:0];

endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - fixed-latency signed 2W/W divider with start/busy/done handshake
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  state_e state_q, state_d;

  logic [2*W-1:0] dividend_q;
  logic [W-1:0]   divisor_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   shift_q;
  logic [W:0]     b_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_quo_q;
  logic           neg_rem_q;
  logic           pre_ovf_q;
  logic           dbz_q;

  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   quotient_q;
  logic [W-1:0]   remainder_q;
  logic           overflow_q;
  logic           div_by_zero_q;

  logic [2*W-1:0] a_abs;
  logic [W:0]     divisor_ext;
  logic [W:0]     b_abs;
  logic [W-1:0]   step_rem;
  logic           step_qbit;
  logic           fix_ovf;

  // Magnitudes; the divisor is widened first so -2^(W-1) stays exact.
  assign a_abs       = dividend_q[2*W-1] ? -dividend_q : dividend_q;
  assign divisor_ext = {divisor_q[W-1], divisor_q};
  assign b_abs       = divisor_q[W-1] ? -divisor_ext : divisor_ext;

  // Overflow covers both the upper-half pre-check and the asymmetric signed range of the quotient.
  assign fix_ovf = !dbz_q && (pre_ovf_q ||
                              (!neg_quo_q && (shift_q >= HALF)) ||
                              (neg_quo_q && (shift_q > HALF)));

  div_step #(.W(W)) u_step (
    .rem_i      (rem_q),
    .shift_in_i (shift_q[W-1]),
    .b_i        (b_q),
    .rem_o      (step_rem),
    .qbit_o     (step_qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: ITER always runs W steps so latency never depends on the operands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: state_d = ITER;
      ITER: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, sign/abs prep, restoring iteration and signed fix-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_q    <= '0;
      divisor_q     <= '0;
      rem_q         <= '0;
      shift_q       <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      pre_ovf_q     <= 1'b0;
      dbz_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            busy_q     <= 1'b1;
          end
        end
        PREP: begin
          neg_quo_q <= dividend_q[2*W-1] ^ divisor_q[W-1];
          neg_rem_q <= dividend_q[2*W-1];
          b_q       <= b_abs;
          pre_ovf_q <= ({1'b0, a_abs[2*W-1:W]} >= b_abs);
          dbz_q     <= (divisor_q == '0);
          rem_q     <= a_abs[2*W-1:W];
          shift_q   <= a_abs[W-1:0];
          cnt_q     <= CW'(W - 1);
        end
        ITER: begin
          rem_q   <= step_rem;
          shift_q <= {shift_q[W-2:0], step_qbit};
          cnt_q   <= cnt_q - CW'(1);
        end
        FIX: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (dbz_q) begin
            div_by_zero_q <= 1'b1;
            overflow_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
          end else if (fix_ovf) begin
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b1;
            quotient_q    <= '0;
            remainder_q   <= '0;
          end else begin
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            quotient_q    <= neg_quo_q ? -shift_q : shift_q;
            remainder_q   <= neg_rem_q ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - scoreboard bench for seq_signed_divider
module tb_seq_signed_divider;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           overflow;
  logic           div_by_zero;

  typedef struct {
    logic [31:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t dir_tab[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  seq_signed_divider #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] dd, input logic [15:0] dv);
    exp_t   e;
    longint a, b, qq, rr;
    e.dd = dd; e.dv = dv; e.q = '0; e.r = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.due = 0;
    a = longint'($signed(dd));
    b = longint'($signed(dv));
    if (b == 0) begin
      e.dbz = 1'b1;
    end else begin
      qq = a / b;
      rr = a % b;
      if (qq > 32767 || qq < -32768) e.ovf = 1'b1;
      else begin
        e.q = 16'(qq);
        e.r = 16'(rr);
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse pops one expected result and compares all outputs and latency.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("done_latency", cyc, e.due);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Drive one request at the current negedge; start stays high until the caller lowers it.
  task automatic issue(input logic [31:0] dd, input logic [15:0] dv, input bit push,
                       input exp_t e);
    exp_t x;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    if (push) begin
      x = e;
      x.due = cyc + 19;
      sb.push_back(x);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 (cycle %0d)", cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] dd, input logic [15:0] dv,
                              input logic [15:0] q, input logic [15:0] r,
                              input logic ovf, input logic dbz);
    exp_t e;
    e.dd = dd; e.dv = dv; e.q = q; e.r = r; e.ovf = ovf; e.dbz = dbz; e.due = 0;
    return e;
  endfunction

  initial begin
    exp_t        e;
    logic [15:0] t16;
    logic [23:0] t24;
    logic [31:0] rdd;
    logic [15:0] rdv;

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    dir_tab.push_back(mk(32'd12,        16'd4,     16'd3,     16'd0,     1'b0, 1'b0));
    dir_tab.push_back(mk(32'hFFFFFFF9,  16'd2,     16'hFFFD,  16'hFFFF,  1'b0, 1'b0));
    dir_tab.push_back(mk(32'h40000000,  16'h8000,  16'h8000,  16'd0,     1'b0, 1'b0));
    dir_tab.push_back(mk(32'h40000000,  16'h7FFF,  16'd0,     16'd0,     1'b1, 1'b0));
    dir_tab.push_back(mk(32'h00001234,  16'd0,     16'd0,     16'd0,     1'b0, 1'b1));
    dir_tab.push_back(mk(32'h80000000,  16'hFFFF,  16'd0,     16'd0,     1'b1, 1'b0));
    dir_tab.push_back(mk(32'd7,         16'hFFFE,  16'hFFFD,  16'd1,     1'b0, 1'b0));
    dir_tab.push_back(mk(32'hFFFFFFF9,  16'hFFFE,  16'd3,     16'hFFFF,  1'b0, 1'b0));
    dir_tab.push_back(mk(32'hFFFF8000,  16'd1,     16'h8000,  16'd0,     1'b0, 1'b0));
    dir_tab.push_back(mk(32'h00008000,  16'd1,     16'd0,     16'd0,     1'b1, 1'b0));
    dir_tab.push_back(mk(32'd100,       16'd7,     16'd14,    16'd2,     1'b0, 1'b0));

    foreach (dir_tab[i]) begin
      issue(dir_tab[i].dd, dir_tab[i].dv, 1'b1, dir_tab[i]);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_done(40);
      repeat (3) @(negedge clk);
      chk("hold_quotient", 32'(quotient), 32'(dir_tab[i].q));
    end

    // Start while busy is ignored.
    issue(32'd12, 16'd4, 1'b1, mk(32'd12, 16'd4, 16'd3, 16'd0, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    issue(32'd99, 16'd3, 1'b0, mk(32'd99, 16'd3, 16'd33, 16'd0, 1'b0, 1'b0));
    chk("busy_mid_op", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    repeat (25) @(negedge clk);

    // Reset mid-operation aborts with no done pulse; a fresh start then completes.
    issue(32'd100, 16'd7, 1'b1, mk(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    issue(32'd1000, 16'd3, 1'b0, mk(32'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    issue(32'hFFFFFF9C, 16'd7, 1'b1, mk(32'hFFFFFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    wait_done(40);

    // Back-to-back operation with start held high, checked against an integer model.
    @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      case ($urandom_range(0, 3))
        0: rdd = $urandom;
        1: begin t16 = 16'($urandom); rdd = {{16{t16[15]}}, t16}; end
        2: begin t24 = 24'($urandom); rdd = {{8{t24[23]}}, t24}; end
        default: rdd = {$urandom_range(0, 1) ? 8'hFF : 8'h00, 24'($urandom)};
      endcase
      case ($urandom_range(0, 7))
        0: rdv = 16'h0000;
        1: rdv = 16'hFFFF;
        2: rdv = 16'h8000;
        3: rdv = 16'h0001;
        default: rdv = 16'($urandom);
      endcase
      e = model(rdd, rdv);
      issue(rdd, rdv, 1'b1, e);
      wait_done(40);
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
